fpu_issuer: RTL

FPU_ISSUER -- requirements
Module: fpu_issuer

---
 rtl/fpu_issuer_if.sv | 44 ++++
 rtl/fpu_issuer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fpu_issuer_if.sv
// Bundles the core-side instruction handshake and the FPU-side order/result
// handshake of the FP issuer; the issuer connects through the slave modport.
interface fpu_issuer_if #(
  parameter int LEN_WORD   = 32,
  parameter int LEN_FUNC3  = 3,
  parameter int LEN_FUNC7  = 7,
  parameter int LEN_REGIDX = 5
);
  logic                  req;
  logic                  flush;
  logic [LEN_FUNC3-1:0]  in_func3;
  logic [LEN_FUNC7-1:0]  in_func7;
  logic [LEN_WORD-1:0]   in_src1;
  logic [LEN_WORD-1:0]   in_src2;
  logic [LEN_REGIDX-1:0] in_rdidx;
  logic                  stall;
  logic                  wb_en;
  logic [LEN_REGIDX-1:0] wb_idx;
  logic [LEN_WORD-1:0]   wb_data;
  logic                  order;
  logic [LEN_FUNC3-1:0]  func3;
  logic [LEN_FUNC7-1:0]  func7;
  logic [LEN_WORD-1:0]   rs1;
  logic [LEN_WORD-1:0]   rs2;
  logic                  calculated;
  logic [LEN_WORD-1:0]   rd;
  logic                  running;
  logic                  err_timeout;
  logic                  err_proto;

  modport master (
    output req, flush, in_func3, in_func7, in_src1, in_src2, in_rdidx,
           calculated, rd, running,
    input  stall, wb_en, wb_idx, wb_data, order, func3, func7, rs1, rs2,
           err_timeout, err_proto
  );

  modport slave (
    input  req, flush, in_func3, in_func7, in_src1, in_src2, in_rdidx,
           calculated, rd, running,
    output stall, wb_en, wb_idx, wb_data, order, func3, func7, rs1, rs2,
           err_timeout, err_proto
  );
endinterface

// File: rtl/fpu_issuer.sv
// Issues one FP instruction at a time to an external FPU, stalls the core
// until the result is written back, and handles flush, timeout and protocol errors.
module fpu_issuer #(
  parameter int LEN_WORD   = 32,
  parameter int LEN_FUNC3  = 3,
  parameter int LEN_FUNC7  = 7,
  parameter int LEN_REGIDX = 5,
  parameter int TIMEOUT    = 64
) (
  input logic         clk,
  input logic         rstn,
  fpu_issuer_if.slave fpu
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic [LEN_FUNC3-1:0]  func3_q;
  logic [LEN_FUNC7-1:0]  func7_q;
  logic [LEN_WORD-1:0]   src1_q;
  logic [LEN_WORD-1:0]   src2_q;
  logic [LEN_REGIDX-1:0] rdidx_q;
  logic [LEN_WORD-1:0]   wbdata_q;
  logic                  order_q;
  logic                  err_timeout_q;
  logic                  err_proto_q;
  logic                  accept;
  logic                  cnt_last;
  logic                  timeout_hit;
  logic                  proto_hit;

  assign accept   = (state == IDLE) && fpu.req && !fpu.flush;
  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    proto_hit   = 1'b0;
    case (state)
      IDLE: begin
        proto_hit = fpu.calculated;
        if (accept) next_state = ISSUE;
      end
      ISSUE: begin
        proto_hit  = fpu.calculated;
        next_state = fpu.flush ? IDLE : WAIT;
      end
      WAIT: begin
        // The FPU must keep running until it answers; the first cycle is exempt.
        proto_hit = (cnt != '0) && !fpu.calculated && !fpu.running;
        if (fpu.flush) begin
          next_state = fpu.calculated ? IDLE : DRAIN;
        end else if (fpu.calculated) begin
          next_state = DONE;
        end else if (cnt_last) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        proto_hit  = fpu.calculated;
        next_state = IDLE;
      end
      DRAIN: begin
        if (fpu.calculated) begin
          next_state = IDLE;
        end else if (cnt_last) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Counter keeps running across WAIT->DRAIN so a flushed op still times out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if ((state == ISSUE) || ((state == WAIT) && fpu.calculated)) begin
      cnt <= '0;
    end else if (((state == WAIT) || (state == DRAIN)) && !cnt_last) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      func3_q <= '0;
      func7_q <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      rdidx_q <= '0;
      order_q <= 1'b0;
    end else begin
      order_q <= accept;
      if (accept) begin
        func3_q <= fpu.in_func3;
        func7_q <= fpu.in_func7;
        src1_q  <= fpu.in_src1;
        src2_q  <= fpu.in_src2;
        rdidx_q <= fpu.in_rdidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbdata_q      <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      if ((state == WAIT) && fpu.calculated && !fpu.flush) wbdata_q <= fpu.rd;
      if (timeout_hit) err_timeout_q <= 1'b1;
      if (proto_hit)   err_proto_q   <= 1'b1;
    end
  end

  // A flush in the ISSUE cycle suppresses the already-registered order pulse.
  assign fpu.order       = order_q && !fpu.flush;
  assign fpu.stall       = accept || (state == ISSUE) || (state == WAIT) ||
                           ((state == DRAIN) && fpu.req);
  assign fpu.wb_en       = (state == DONE) && !fpu.flush;
  assign fpu.wb_idx      = rdidx_q;
  assign fpu.wb_data     = wbdata_q;
  assign fpu.func3       = func3_q;
  assign fpu.func7       = func7_q;
  assign fpu.rs1         = src1_q;
  assign fpu.rs2         = src2_q;
  assign fpu.err_timeout = err_timeout_q;
  assign fpu.err_proto   = err_proto_q;
endmodule
